zx_video_fetch: RTL and testbench

Reads the ZX Spectrum 48K screen from the read port of the dual-port video RAM: bitmap and attribute bytes. Turns them into a 4-bit RGBI pixel stream with border, flash, blanking, syncs and the Z80 frame interrupt. The CPU side writes the same RAM through the write port. This block is the only reader of the read port and sits between video RAM and the video output stage.

---
 rtl/zx_video_fetch.sv | 158 +++++++++++++++
 tb/tb_zx_video_fetch.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zx_video_fetch.sv
// zx_video_fetch: ZX Spectrum 48K screen fetcher and RGBI raster generator.
// Reads bitmap/attribute bytes from video RAM, emits pixels, syncs and IRQ.
module zx_video_fetch #(
  parameter int AW = 13
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ce,
  input  logic [2:0]    border,
  output logic          mce,
  output logic [AW-1:0] ma,
  input  logic [7:0]    mq,
  output logic [3:0]    rgbi,
  output logic          blank,
  output logic          hsync,
  output logic          vsync,
  output logic          irq
);

  localparam logic [8:0] H_LAST = 9'd447;
  localparam logic [8:0] V_LAST = 9'd311;

  logic [8:0]  hc;
  logic [8:0]  vc;
  logic [4:0]  fcnt;

  logic        fetch_area;
  logic        rd_bmp;
  logic        rd_att;
  logic        rd_go;
  logic [12:0] bmp_addr;
  logic [12:0] att_addr;
  logic [12:0] rd_addr;

  logic        mce_att;
  logic        pend;
  logic        pend_att;
  logic [7:0]  bmp_lat;
  logic [7:0]  att_lat;
  logic [7:0]  shift;
  logic [7:0]  attr;

  logic        in_win;
  logic        in_blank;
  logic        in_hs;
  logic        in_vs;
  logic        in_irq;
  logic        pix;
  logic [2:0]  pix_col;
  logic [3:0]  rgbi_nx;

  // Raster counters
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hc   <= '0;
      vc   <= '0;
      fcnt <= '0;
    end else if (ce) begin
      if (hc == H_LAST) begin
        hc <= '0;
        if (vc == V_LAST) begin
          vc   <= '0;
          fcnt <= fcnt + 5'd1;
        end else begin
          vc <= vc + 9'd1;
        end
      end else begin
        hc <= hc + 9'd1;
      end
    end
  end

  always_comb begin
    fetch_area = (vc < 9'd192) && (hc < 9'd256);
    rd_bmp     = fetch_area && (hc[2:0] == 3'd0);
    rd_att     = fetch_area && (hc[2:0] == 3'd2);
    rd_go      = ce && (rd_bmp || rd_att);
    bmp_addr   = {vc[7:6], vc[2:0], vc[5:3], hc[7:3]};
    att_addr   = 13'h1800 + {3'b000, vc[7:3], hc[7:3]};
    rd_addr    = rd_att ? att_addr : bmp_addr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mce     <= 1'b0;
      mce_att <= 1'b0;
      ma      <= '0;
    end else begin
      mce <= rd_go;
      if (rd_go) begin
        mce_att <= rd_att;
        ma      <= AW'(rd_addr);
      end
    end
  end

  // RAM returns data one clock after it samples mce; latch regardless of ce
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend     <= 1'b0;
      pend_att <= 1'b0;
      bmp_lat  <= '0;
      att_lat  <= '0;
    end else begin
      pend     <= mce;
      pend_att <= mce_att;
      if (pend) begin
        if (pend_att) att_lat <= mq;
        else          bmp_lat <= mq;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shift <= '0;
      attr  <= '0;
    end else if (ce) begin
      if (hc[2:0] == 3'd7) begin
        shift <= bmp_lat;
        attr  <= att_lat;
      end else begin
        shift <= {shift[6:0], 1'b0};
      end
    end
  end

  always_comb begin
    in_win   = (vc < 9'd192) && (hc >= 9'd8) && (hc < 9'd264);
    in_blank = ((hc >= 9'd320) && (hc <= 9'd415))
            || ((vc >= 9'd248) && (vc <= 9'd255));
    in_hs    = (hc >= 9'd344) && (hc <= 9'd375);
    in_vs    = (vc >= 9'd248) && (vc <= 9'd251);
    in_irq   = (vc == 9'd248) && (hc < 9'd64);
    pix      = shift[7] ^ (attr[7] & fcnt[4]);
    pix_col  = pix ? attr[2:0] : attr[5:3];
    rgbi_nx  = {border, 1'b0};
    if (in_blank)    rgbi_nx = 4'd0;
    else if (in_win) rgbi_nx = {pix_col, attr[6]};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgbi  <= '0;
      blank <= 1'b1;
      hsync <= 1'b0;
      vsync <= 1'b0;
      irq   <= 1'b0;
    end else if (ce) begin
      rgbi  <= rgbi_nx;
      blank <= in_blank;
      hsync <= in_hs;
      vsync <= in_vs;
      irq   <= in_irq;
    end
  end

endmodule

// File: tb/tb_zx_video_fetch.sv
// tb_zx_video_fetch: scoreboard bench for the ZX screen fetcher.
// Expected pixels/reads are queued by position; a monitor checks them.
module tb_zx_video_fetch;

  logic        clock;
  logic        reset;
  logic        ce;
  logic [2:0]  border;
  logic        mce;
  logic [12:0] ma;
  logic [7:0]  mq;
  logic [3:0]  rgbi;
  logic        blank;
  logic        hsync;
  logic        vsync;
  logic        irq;

  zx_video_fetch #(.AW(13)) dut (
    .clock (clock),
    .reset (reset),
    .ce    (ce),
    .border(border),
    .mce   (mce),
    .ma    (ma),
    .mq    (mq),
    .rgbi  (rgbi),
    .blank (blank),
    .hsync (hsync),
    .vsync (vsync),
    .irq   (irq)
  );

  typedef struct {
    int         vc;
    int         hc;
    logic [3:0] rgbi;
    logic       blank;
    logic       hs;
    logic       vs;
    logic       irq;
  } pix_t;

  typedef struct {
    int          vc;
    int          hc;
    logic        rd;
    logic [12:0] ma;
  } rd_t;

  pix_t pq[$];
  rd_t  rq[$];

  logic [7:0] ram [0:8191];
  int checks;
  int failures;
  int mvc;
  int mhc;
  int phase;
  logic run;
  logic gap;
  logic [8:0] jv;
  logic [8:0] jh;
  logic [4:0] jf;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock)
    if (mce) mq <= ram[ma];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s vc=%0d hc=%0d got=0x%0h expected=0x%0h",
               name, mvc, mhc, act, exp);
    end
  endtask

  task automatic push_pix(input int v, input int h, input int c,
                          input bit bl, input bit hs,
                          input bit vs, input bit iq);
    pix_t p;
    p.vc = v; p.hc = h; p.rgbi = 4'(c);
    p.blank = bl; p.hs = hs; p.vs = vs; p.irq = iq;
    pq.push_back(p);
  endtask

  task automatic push_rd(input int v, input int h, input bit rd,
                         input int a);
    rd_t r;
    r.vc = v; r.hc = h; r.rd = rd; r.ma = 13'(a);
    rq.push_back(r);
  endtask

  // Monitor: each ce edge is one raster position
  always @(posedge clock) begin
    logic cev;
    logic rv;
    pix_t p;
    rd_t  r;
    cev = ce;
    rv  = reset;
    #1;
    if (!rv) begin
      if (!cev) begin
        chk("mce_idle", int'(mce), 0);
      end else begin
        if (pq.size() > 0 && pq[0].vc == mvc && pq[0].hc == mhc) begin
          p = pq.pop_front();
          chk("rgbi", int'(rgbi), int'(p.rgbi));
          chk("blank", int'(blank), int'(p.blank));
          chk("hsync", int'(hsync), int'(p.hs));
          chk("vsync", int'(vsync), int'(p.vs));
          chk("irq", int'(irq), int'(p.irq));
        end
        if (rq.size() > 0 && rq[0].vc == mvc && rq[0].hc == mhc) begin
          r = rq.pop_front();
          chk("mce", int'(mce), int'(r.rd));
          if (r.rd) chk("ma", int'(ma), int'(r.ma));
        end
        if (mhc == 447) begin
          mhc = 0;
          mvc = (mvc == 311) ? 0 : mvc + 1;
        end else begin
          mhc = mhc + 1;
        end
      end
    end
  end

  task tick();
    @(negedge clock);
    phase++;
    ce = run && (!gap || (phase % 4 == 0));
  endtask

  task jump(input int v, input int h, input int f);
    run = 1'b0;
    tick();
    jv = 9'(v);
    jh = 9'(h);
    jf = 5'(f);
    force dut.vc = jv;
    force dut.hc = jh;
    force dut.fcnt = jf;
    mvc = v;
    mhc = h;
    @(negedge clock);
    release dut.vc;
    release dut.hc;
    release dut.fcnt;
    run = 1'b1;
    phase = 0;
    ce = 1'b1;
  endtask

  task chk_reset_outs(input string tag);
    chk({tag, "_mce"}, int'(mce), 0);
    chk({tag, "_ma"}, int'(ma), 0);
    chk({tag, "_rgbi"}, int'(rgbi), 0);
    chk({tag, "_blank"}, int'(blank), 1);
    chk({tag, "_hsync"}, int'(hsync), 0);
    chk({tag, "_vsync"}, int'(vsync), 0);
    chk({tag, "_irq"}, int'(irq), 0);
  endtask

  initial begin
    checks = 0; failures = 0;
    mvc = 0; mhc = 0; phase = 0;
    run = 1'b0; gap = 1'b0;
    reset = 1'b1; ce = 1'b0; border = 3'b101;
    for (int i = 0; i < 8192; i++) ram[i] = 8'h00;
    ram[13'h0000] = 8'hF0;
    ram[13'h1800] = 8'h47;
    ram[13'h0905] = 8'hAA;
    ram[13'h1905] = 8'h87;
    ram[13'h091F] = 8'h0F;
    ram[13'h191F] = 8'h38;
    ram[13'h0C80] = 8'h3C;
    ram[13'h1980] = 8'h0A;

    // Reset, then two idle clocks before the first ce
    repeat (3) @(negedge clock);
    chk_reset_outs("rst");
    reset = 1'b0;
    repeat (2) tick();
    chk_reset_outs("idle");

    push_rd(0, 0, 1, 'h0000);
    push_rd(0, 1, 0, 0);
    push_rd(0, 2, 1, 'h1800);
    push_rd(0, 8, 1, 'h0001);
    push_rd(0, 10, 1, 'h1801);
    for (int h = 0; h < 8; h++) push_pix(0, h, 'hA, 0, 0, 0, 0);
    for (int h = 8; h < 12; h++) push_pix(0, h, 'hF, 0, 0, 0, 0);
    for (int h = 12; h < 16; h++) push_pix(0, h, 'h1, 0, 0, 0, 0);
    for (int h = 16; h < 24; h++) push_pix(0, h, 'h0, 0, 0, 0, 0);
    run = 1'b1;
    repeat (30) tick();

    // Address order at line 65, then flash off/on
    jump(65, 40, 0);
    push_rd(65, 40, 1, 'h0905);
    push_rd(65, 42, 1, 'h1905);
    for (int h = 48; h < 56; h++)
      push_pix(65, h, (h % 2 == 0) ? 'hE : 'h0, 0, 0, 0, 0);
    repeat (20) tick();
    jump(65, 32, 16);
    push_rd(65, 40, 1, 'h0905);
    for (int h = 48; h < 56; h++)
      push_pix(65, h, (h % 2 == 0) ? 'h0 : 'hE, 0, 0, 0, 0);
    repeat (26) tick();

    // Cell 31 drawn in hc 256..263, no read at hc 256
    jump(65, 240, 0);
    push_rd(65, 248, 1, 'h091F);
    push_rd(65, 250, 1, 'h191F);
    push_rd(65, 256, 0, 0);
    for (int h = 256; h < 260; h++) push_pix(65, h, 'hE, 0, 0, 0, 0);
    for (int h = 260; h < 264; h++) push_pix(65, h, 'h0, 0, 0, 0, 0);
    push_pix(65, 264, 'hA, 0, 0, 0, 0);
    repeat (30) tick();

    // Border, blank and hsync across line 200
    border = 3'b010;
    jump(200, 96, 0);
    push_rd(200, 96, 0, 0);
    for (int h = 96; h < 448; h++) begin
      bit bl;
      bl = (h >= 320) && (h <= 415);
      push_pix(200, h, bl ? 0 : 'h4, bl, (h >= 344) && (h <= 375), 0, 0);
    end
    repeat (360) tick();

    // vsync / irq around line 248, vertical blank edges
    jump(247, 440, 0);
    for (int h = 440; h < 448; h++) push_pix(247, h, 'h4, 0, 0, 0, 0);
    for (int h = 0; h <= 80; h++) push_pix(248, h, 0, 1, 0, 1, h < 64);
    repeat (95) tick();
    jump(251, 444, 0);
    for (int h = 444; h < 448; h++) push_pix(251, h, 0, 1, 0, 1, 0);
    for (int h = 0; h < 4; h++) push_pix(252, h, 0, 1, 0, 0, 0);
    repeat (12) tick();
    jump(255, 444, 0);
    for (int h = 444; h < 448; h++) push_pix(255, h, 0, 1, 0, 0, 0);
    for (int h = 0; h < 4; h++) push_pix(256, h, 'h4, 0, 0, 0, 0);
    repeat (12) tick();

    // Frame wrap bumps fcnt 15 -> 16, flash inverts cell 0
    ram[13'h1800] = 8'hC7;
    jump(311, 440, 15);
    for (int h = 440; h < 448; h++) push_pix(311, h, 'h4, 0, 0, 0, 0);
    push_rd(0, 0, 1, 'h0000);
    push_rd(0, 2, 1, 'h1800);
    for (int h = 0; h < 8; h++) push_pix(0, h, 'h4, 0, 0, 0, 0);
    for (int h = 8; h < 12; h++) push_pix(0, h, 'h1, 0, 0, 0, 0);
    for (int h = 12; h < 16; h++) push_pix(0, h, 'hF, 0, 0, 0, 0);
    repeat (30) tick();

    // Gapped ce, 1 clock in 4
    gap = 1'b1;
    jump(100, 0, 0);
    push_rd(100, 0, 1, 'h0C80);
    push_rd(100, 2, 1, 'h1980);
    push_rd(100, 24, 1, 'h0C83);
    for (int h = 0; h < 8; h++) push_pix(100, h, 'h4, 0, 0, 0, 0);
    push_pix(100, 8, 'h2, 0, 0, 0, 0);
    push_pix(100, 9, 'h2, 0, 0, 0, 0);
    for (int h = 10; h < 14; h++) push_pix(100, h, 'h4, 0, 0, 0, 0);
    push_pix(100, 14, 'h2, 0, 0, 0, 0);
    push_pix(100, 15, 'h2, 0, 0, 0, 0);
    for (int n = 0; n < 400 && !(mvc == 100 && mhc == 25); n++) tick();
    chk("reach_pos", mhc, 25);

    // Async reset while a read is in flight
    chk("pre_rst_mce", int'(mce), 1);
    chk("pre_rst_ma", int'(ma), 'h0C83);
    chk("pre_rst_blank", int'(blank), 0);
    reset = 1'b1;
    mvc = 0;
    mhc = 0;
    #1;
    chk_reset_outs("async");
    run = 1'b0;
    gap = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    push_rd(0, 0, 1, 'h0000);
    push_rd(0, 2, 1, 'h1800);
    for (int h = 8; h < 12; h++) push_pix(0, h, 'hF, 0, 0, 0, 0);
    for (int h = 12; h < 16; h++) push_pix(0, h, 'h1, 0, 0, 0, 0);
    run = 1'b1;
    repeat (30) tick();

    run = 1'b0;
    repeat (2) tick();
    chk("pix_left", pq.size(), 0);
    chk("rd_left", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
